// File: rtl/exe_arbiter.sv
// exe_arbiter
// Shares one registered execution unit between two requesters. Arbitration is
// round-robin. Each operation runs as accept -> issue -> wait -> respond, and
// only one operation is in flight at a time. The response is held until the
// consumer takes it.
//
// State table
//   IDLE  | grant a requester, latch its operands and id
//   ISSUE | operands presented; the execution unit samples them at cycle end
//   WAIT  | execution unit output is valid; capture it at cycle end
//   RESP  | response held on o_rsp_*; wait for i_rsp_ready
//
// Ports
//   i_clk, i_rsn                      clock, async active-low reset
//   i_reqK_valid/oper/argA/argB       request from port K (K = 0, 1)
//   o_reqK_ready                      accept for port K (IDLE only)
//   o_exe_oper/argA/argB              registered operands to the execution unit
//   i_exe_result/status               registered output of the execution unit
//   o_rsp_valid/id/result/status/err  buffered response
//   i_rsp_ready                       response accept
module exe_arbiter #(
  parameter int m        = 4,
  parameter int n        = 2,
  parameter int OPER_MAX = 2
) (
  input  logic         i_clk,
  input  logic         i_rsn,
  input  logic         i_req0_valid,
  input  logic [n-1:0] i_req0_oper,
  input  logic [m-1:0] i_req0_argA,
  input  logic [m-1:0] i_req0_argB,
  output logic         o_req0_ready,
  input  logic         i_req1_valid,
  input  logic [n-1:0] i_req1_oper,
  input  logic [m-1:0] i_req1_argA,
  input  logic [m-1:0] i_req1_argB,
  output logic         o_req1_ready,
  output logic [n-1:0] o_exe_oper,
  output logic [m-1:0] o_exe_argA,
  output logic [m-1:0] o_exe_argB,
  input  logic [m-1:0] i_exe_result,
  input  logic [3:0]   i_exe_status,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic         o_rsp_id,
  output logic [m-1:0] o_rsp_result,
  output logic [3:0]   o_rsp_status,
  output logic         o_rsp_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t       state_q,  state_d;
  logic         rr_q,     rr_d;
  logic         id_q,     id_d;
  logic [n-1:0] oper_q,   oper_d;
  logic [m-1:0] arga_q,   arga_d;
  logic [m-1:0] argb_q,   argb_d;
  logic [m-1:0] result_q, result_d;
  logic [3:0]   status_q, status_d;
  logic         err_q,    err_d;

  logic         gnt0, gnt1;
  logic         ready0, ready1;
  logic [n-1:0] sel_oper;

  // A lone valid wins outright; on contention the rr pointer picks the port.
  assign gnt0 = i_req0_valid & (~i_req1_valid | ~rr_q);
  assign gnt1 = i_req1_valid & (~i_req0_valid |  rr_q);

  assign sel_oper = gnt1 ? i_req1_oper : i_req0_oper;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    id_d     = id_q;
    oper_d   = oper_q;
    arga_d   = arga_q;
    argb_d   = argb_q;
    result_d = result_q;
    status_d = status_q;
    err_d    = err_q;
    ready0   = 1'b0;
    ready1   = 1'b0;

    case (state_q)
      IDLE: begin
        // Readies are gated by reset so no port sees an accept while held in reset.
        ready0 = i_rsn & gnt0;
        ready1 = i_rsn & gnt1;
        if (ready0 | ready1) begin
          id_d   = ready1;
          oper_d = sel_oper;
          arga_d = ready1 ? i_req1_argA : i_req0_argA;
          argb_d = ready1 ? i_req1_argB : i_req0_argB;
          if (int'(sel_oper) > OPER_MAX) begin
            // Unsupported opcode: answer directly, the unit never sees it.
            err_d    = 1'b1;
            result_d = '0;
            status_d = '0;
            state_d  = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        result_d = i_exe_result;
        status_d = i_exe_status;
        err_d    = 1'b0;
        state_d  = RESP;
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
          rr_d    = ~id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      id_q     <= 1'b0;
      oper_q   <= '0;
      arga_q   <= '0;
      argb_q   <= '0;
      result_q <= '0;
      status_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      id_q     <= id_d;
      oper_q   <= oper_d;
      arga_q   <= arga_d;
      argb_q   <= argb_d;
      result_q <= result_d;
      status_q <= status_d;
      err_q    <= err_d;
    end
  end

  assign o_req0_ready = ready0;
  assign o_req1_ready = ready1;
  assign o_exe_oper   = oper_q;
  assign o_exe_argA   = arga_q;
  assign o_exe_argB   = argb_q;
  assign o_rsp_valid  = (state_q == RESP);
  assign o_rsp_id     = id_q;
  assign o_rsp_result = result_q;
  assign o_rsp_status = status_q;
  assign o_rsp_err    = err_q;

endmodule

// File: tb/tb_exe_arbiter.sv
module tb_exe_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rsn = 1'b0;
  logic       i_req0_valid = 1'b0;
  logic [1:0] i_req0_oper  = '0;
  logic [3:0] i_req0_argA  = '0;
  logic [3:0] i_req0_argB  = '0;
  logic       o_req0_ready;
  logic       i_req1_valid = 1'b0;
  logic [1:0] i_req1_oper  = '0;
  logic [3:0] i_req1_argA  = '0;
  logic [3:0] i_req1_argB  = '0;
  logic       o_req1_ready;
  logic [1:0] o_exe_oper;
  logic [3:0] o_exe_argA;
  logic [3:0] o_exe_argB;
  logic [3:0] i_exe_result = '0;
  logic [3:0] i_exe_status = '0;
  logic       o_rsp_valid;
  logic       i_rsp_ready = 1'b1;
  logic       o_rsp_id;
  logic [3:0] o_rsp_result;
  logic [3:0] o_rsp_status;
  logic       o_rsp_err;

  int compared   = 0;
  int mismatched = 0;

  exe_arbiter dut (
    .i_clk        (i_clk),
    .i_rsn        (i_rsn),
    .i_req0_valid (i_req0_valid),
    .i_req0_oper  (i_req0_oper),
    .i_req0_argA  (i_req0_argA),
    .i_req0_argB  (i_req0_argB),
    .o_req0_ready (o_req0_ready),
    .i_req1_valid (i_req1_valid),
    .i_req1_oper  (i_req1_oper),
    .i_req1_argA  (i_req1_argA),
    .i_req1_argB  (i_req1_argB),
    .o_req1_ready (o_req1_ready),
    .o_exe_oper   (o_exe_oper),
    .o_exe_argA   (o_exe_argA),
    .o_exe_argB   (o_exe_argB),
    .i_exe_result (i_exe_result),
    .i_exe_status (i_exe_status),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_result (o_rsp_result),
    .o_rsp_status (o_rsp_status),
    .o_rsp_err    (o_rsp_err)
  );

  always #5 i_clk = ~i_clk;

  // Execution unit stand-in: 0 add, 1 sub, 2 xor; status = {zero, 0, oper}.
  always @(posedge i_clk) begin
    logic [3:0] r;
    case (o_exe_oper)
      2'd0:    r = o_exe_argA + o_exe_argB;
      2'd1:    r = o_exe_argA - o_exe_argB;
      2'd2:    r = o_exe_argA ^ o_exe_argB;
      default: r = 4'd0;
    endcase
    i_exe_result <= r;
    i_exe_status <= {(r == 4'd0), 1'b0, o_exe_oper};
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 2 time units after the rising edge.
  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  // Expected grant order under continuous contention, starting with pointer 0.
  logic [5:0] exp_ids = 6'b101010;

  initial begin
    // ---- reset with both valids high ----
    i_req0_valid = 1'b1;
    i_req1_valid = 1'b1;
    #22;
    chk("rst_ready0", {7'd0, o_req0_ready}, 8'd0);
    chk("rst_ready1", {7'd0, o_req1_ready}, 8'd0);
    chk("rst_rsp_valid", {7'd0, o_rsp_valid}, 8'd0);
    chk("rst_exe_oper", {6'd0, o_exe_oper}, 8'd0);
    chk("rst_exe_argA", {4'd0, o_exe_argA}, 8'd0);
    chk("rst_exe_argB", {4'd0, o_exe_argB}, 8'd0);
    i_rsn = 1'b1;
    #1;
    chk("rel_ready0", {7'd0, o_req0_ready}, 8'd1);
    chk("rel_ready1", {7'd0, o_req1_ready}, 8'd0);
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    step();

    // ---- single op on port 1: 3 + 5 ----
    i_req1_valid = 1'b1; i_req1_oper = 2'd0; i_req1_argA = 4'd3; i_req1_argB = 4'd5;
    #1;
    chk("single_ready1", {7'd0, o_req1_ready}, 8'd1);
    chk("single_ready0", {7'd0, o_req0_ready}, 8'd0);
    step();
    i_req1_valid = 1'b0;
    #1;
    chk("single_issue_ready1", {7'd0, o_req1_ready}, 8'd0);
    chk("single_issue_argA", {4'd0, o_exe_argA}, 8'd3);
    chk("single_issue_argB", {4'd0, o_exe_argB}, 8'd5);
    chk("single_issue_valid", {7'd0, o_rsp_valid}, 8'd0);
    step();
    chk("single_wait_valid", {7'd0, o_rsp_valid}, 8'd0);
    step();
    chk("single_rsp_valid", {7'd0, o_rsp_valid}, 8'd1);
    chk("single_rsp_id", {7'd0, o_rsp_id}, 8'd1);
    chk("single_rsp_result", {4'd0, o_rsp_result}, 8'd8);
    chk("single_rsp_status", {4'd0, o_rsp_status}, 8'd0);
    chk("single_rsp_err", {7'd0, o_rsp_err}, 8'd0);
    step();
    chk("single_done_valid", {7'd0, o_rsp_valid}, 8'd0);

    // ---- contention: 6 ops, grants must alternate 0,1,0,1,0,1 ----
    i_req0_valid = 1'b1; i_req0_oper = 2'd0; i_req0_argA = 4'd1; i_req0_argB = 4'd1;
    i_req1_valid = 1'b1; i_req1_oper = 2'd2; i_req1_argA = 4'd5; i_req1_argB = 4'd3;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("cont%0d_ready0", k), {7'd0, o_req0_ready}, {7'd0, ~exp_ids[k]});
      chk($sformatf("cont%0d_ready1", k), {7'd0, o_req1_ready}, {7'd0, exp_ids[k]});
      step();
      step();
      chk($sformatf("cont%0d_wait_rdy", k), {6'd0, o_req1_ready, o_req0_ready}, 8'd0);
      step();
      chk($sformatf("cont%0d_rsp_valid", k), {7'd0, o_rsp_valid}, 8'd1);
      chk($sformatf("cont%0d_rsp_id", k), {7'd0, o_rsp_id}, {7'd0, exp_ids[k]});
      chk($sformatf("cont%0d_rsp_result", k), {4'd0, o_rsp_result}, exp_ids[k] ? 8'd6 : 8'd2);
      chk($sformatf("cont%0d_rsp_status", k), {4'd0, o_rsp_status}, exp_ids[k] ? 8'd2 : 8'd0);
      chk($sformatf("cont%0d_rsp_rdy", k), {6'd0, o_req1_ready, o_req0_ready}, 8'd0);
      step();
    end
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;

    // ---- backpressure: port 0, 9 - 4 ----
    i_rsp_ready = 1'b0;
    i_req0_valid = 1'b1; i_req0_oper = 2'd1; i_req0_argA = 4'd9; i_req0_argB = 4'd4;
    #1;
    chk("bp_ready0", {7'd0, o_req0_ready}, 8'd1);
    step();
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b1; i_req1_oper = 2'd0; i_req1_argA = 4'd7; i_req1_argB = 4'd7;
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_valid", c), {7'd0, o_rsp_valid}, 8'd1);
      chk($sformatf("bp%0d_id", c), {7'd0, o_rsp_id}, 8'd0);
      chk($sformatf("bp%0d_result", c), {4'd0, o_rsp_result}, 8'd5);
      chk($sformatf("bp%0d_status", c), {4'd0, o_rsp_status}, 8'd1);
      chk($sformatf("bp%0d_err", c), {7'd0, o_rsp_err}, 8'd0);
      chk($sformatf("bp%0d_rdy", c), {6'd0, o_req1_ready, o_req0_ready}, 8'd0);
      step();
    end
    i_rsp_ready = 1'b1;
    i_req0_valid = 1'b1;
    #1;
    chk("bp_hs_valid", {7'd0, o_rsp_valid}, 8'd1);
    chk("bp_hs_rdy", {6'd0, o_req1_ready, o_req0_ready}, 8'd0);
    step();
    // Pointer flipped to 1: with both valid, port 1 is granted.
    chk("bp_idle_valid", {7'd0, o_rsp_valid}, 8'd0);
    chk("bp_idle_ready1", {7'd0, o_req1_ready}, 8'd1);
    chk("bp_idle_ready0", {7'd0, o_req0_ready}, 8'd0);
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    step();

    // ---- rejected opcode on port 0 ----
    i_req0_valid = 1'b1; i_req0_oper = 2'd3; i_req0_argA = 4'hA; i_req0_argB = 4'hB;
    #1;
    chk("rej_ready0", {7'd0, o_req0_ready}, 8'd1);
    step();
    i_req0_valid = 1'b0;
    #1;
    chk("rej_rsp_valid", {7'd0, o_rsp_valid}, 8'd1);
    chk("rej_rsp_err", {7'd0, o_rsp_err}, 8'd1);
    chk("rej_rsp_result", {4'd0, o_rsp_result}, 8'd0);
    chk("rej_rsp_status", {4'd0, o_rsp_status}, 8'd0);
    chk("rej_rsp_id", {7'd0, o_rsp_id}, 8'd0);
    step();
    chk("rej_done_valid", {7'd0, o_rsp_valid}, 8'd0);

    // ---- reset during WAIT ----
    i_req1_valid = 1'b1; i_req1_oper = 2'd0; i_req1_argA = 4'd2; i_req1_argB = 4'd2;
    #1;
    chk("rw_ready1", {7'd0, o_req1_ready}, 8'd1);
    step();
    i_req1_valid = 1'b0;
    step();
    chk("rw_argA_before", {4'd0, o_exe_argA}, 8'd2);
    #1;
    i_rsn = 1'b0;
    #1;
    chk("rw_async_argA", {4'd0, o_exe_argA}, 8'd0);
    chk("rw_async_argB", {4'd0, o_exe_argB}, 8'd0);
    chk("rw_async_valid", {7'd0, o_rsp_valid}, 8'd0);
    step();
    step();
    i_rsn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("rw_post%0d_valid", c), {7'd0, o_rsp_valid}, 8'd0);
    end
    i_req0_valid = 1'b1;
    i_req1_valid = 1'b1;
    #1;
    chk("rw_post_ready0", {7'd0, o_req0_ready}, 8'd1);
    chk("rw_post_ready1", {7'd0, o_req1_ready}, 8'd0);
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
